// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one shared single-port RAM
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic                  mem_gnt_o,
    output logic                  mem_rvalid_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic                  ram_ack_i,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] streak_q;
    logic       flush_q;
    logic       if_wins;
    logic       done;

    // MEM normally wins a tie; IF takes over once MEM has won STREAK_MAX in a row.
    assign if_wins = if_req_i && (!mem_req_i || streak_q == STREAK_MAX);
    assign done    = (state_q != IDLE) && ram_ack_i;
    assign busy_o  = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (if_wins) begin
                    state_d = BUSY_I;
                end else if (mem_req_i) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (ram_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o  = (state_q == IDLE) && if_wins;
        mem_gnt_o = (state_q == IDLE) && mem_req_i && !if_wins;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_req_o    <= 1'b0;
            ram_we_o     <= 1'b0;
            ram_addr_o   <= '0;
            ram_wdata_o  <= '0;
            if_rvalid_o  <= 1'b0;
            if_rdata_o   <= '0;
            mem_rvalid_o <= 1'b0;
            mem_rdata_o  <= '0;
        end else begin
            if_rvalid_o  <= 1'b0;
            mem_rvalid_o <= 1'b0;
            if (if_gnt_o) begin
                ram_req_o   <= 1'b1;
                ram_we_o    <= 1'b0;
                ram_addr_o  <= if_addr_i;
                ram_wdata_o <= '0;
            end else if (mem_gnt_o) begin
                ram_req_o   <= 1'b1;
                ram_we_o    <= mem_we_i;
                ram_addr_o  <= mem_addr_i;
                ram_wdata_o <= mem_wdata_i;
            end else if (done) begin
                ram_req_o <= 1'b0;
                if (state_q == BUSY_I) begin
                    // A flush arriving on the ack cycle itself still drops the response.
                    if (!(flush_q || if_flush_i)) begin
                        if_rvalid_o <= 1'b1;
                        if_rdata_o  <= ram_rdata_i;
                    end
                end else begin
                    mem_rvalid_o <= 1'b1;
                    mem_rdata_o  <= ram_we_o ? '0 : ram_rdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_q  <= 1'b0;
            streak_q <= 4'd0;
        end else begin
            if (state_q == BUSY_I && ram_ack_i) begin
                flush_q <= 1'b0;
            end else if ((state_q == BUSY_I || if_gnt_o) && if_flush_i) begin
                flush_q <= 1'b1;
            end

            if (if_gnt_o || !if_req_i) begin
                streak_q <= 4'd0;
            end else if (mem_gnt_o && streak_q != STREAK_MAX) begin
                streak_q <= streak_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_i;
    logic        if_req_i;
    logic [15:0] if_addr_i;
    logic        if_flush_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [15:0] if_rdata_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [15:0] mem_addr_i;
    logic [15:0] mem_wdata_i;
    logic        mem_gnt_o;
    logic        mem_rvalid_o;
    logic [15:0] mem_rdata_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [15:0] ram_addr_o;
    logic [15:0] ram_wdata_o;
    logic        ram_ack_i;
    logic [15:0] ram_rdata_i;
    logic        busy_o;

    logic        auto_ack;
    logic        man_ack;
    int          ram_lat;
    int          ack_count;
    logic [15:0] ram_mem [0:1023];
    logic [15:0] ref_mem [0:1023];

    int checks;
    int errors;

    assign ram_ack_i = auto_ack | man_ack;

    mem_port_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_gnt_o   (mem_gnt_o),
        .mem_rvalid_o(mem_rvalid_o),
        .mem_rdata_o (mem_rdata_o),
        .ram_req_o   (ram_req_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_ack_i   (ram_ack_i),
        .ram_rdata_i (ram_rdata_i),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM responder: acks after ram_lat cycles of ram_req (0 = random 1..3 per transaction).
    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 1;
        auto_ack = 1'b0;
        ack_count = 0;
        ram_rdata_i = 16'h0;
        for (int i = 0; i < 1024; i++) ram_mem[i] = 16'hA000 ^ 16'(i);
        ram_mem[16] = 16'hBEEF;
        forever begin
            @(posedge clk);
            #1;
            if (ram_req_o) begin
                if (cnt == 0) cur_lat = (ram_lat == 0) ? int'($urandom_range(1, 3)) : ram_lat;
                cnt++;
                if (cnt >= cur_lat) begin
                    auto_ack = 1'b1;
                    ack_count++;
                    ram_rdata_i = ram_mem[ram_addr_o[9:0]];
                    if (ram_we_o) ram_mem[ram_addr_o[9:0]] = ram_wdata_o;
                    cnt = 0;
                end else begin
                    auto_ack = 1'b0;
                end
            end else begin
                auto_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy_o && k < 50) begin
            drive_edge();
            sample();
            k++;
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout: busy_o=%b required 0", name, busy_o); end
        drive_edge();
        sample();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        man_ack = 0; ram_lat = 1;
        drive_edge();
        drive_edge();
        sample();
        checks++; if (ram_req_o !== 1'b0) begin errors++; $display("FAIL reset_ram_req: got %b required 0", ram_req_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        checks++; if ({if_rvalid_o, mem_rvalid_o, if_gnt_o, mem_gnt_o, ram_we_o} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b required 00000", {if_rvalid_o, mem_rvalid_o, if_gnt_o, mem_gnt_o, ram_we_o}); end
        checks++; if ({if_rdata_o, mem_rdata_o, ram_addr_o, ram_wdata_o} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h required 0", {if_rdata_o, mem_rdata_o, ram_addr_o, ram_wdata_o}); end
        drive_edge();
        rst_i = 1'b0;
        sample();
    endtask

    task automatic test_if_only();
        drive_edge();
        ram_lat = 1;
        if_req_i = 1; if_addr_i = 16'h0010;
        sample();
        checks++; if (if_gnt_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL if_only_t0: gnt=%b busy=%b required gnt=1 busy=0", if_gnt_o, busy_o); end
        drive_edge();
        if_req_i = 0;
        sample();
        checks++; if (ram_req_o !== 1'b1 || busy_o !== 1'b1 || ram_addr_o !== 16'h0010 || ram_we_o !== 1'b0) begin errors++; $display("FAIL if_only_t1: req=%b busy=%b addr=%h we=%b required 1 1 0010 0", ram_req_o, busy_o, ram_addr_o, ram_we_o); end
        drive_edge();
        sample();
        checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 16'hBEEF || busy_o !== 1'b0) begin errors++; $display("FAIL if_only_t2: rvalid=%b rdata=%h busy=%b required 1 beef 0", if_rvalid_o, if_rdata_o, busy_o); end
        drive_edge();
        sample();
        checks++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== 16'hBEEF) begin errors++; $display("FAIL if_only_hold: rvalid=%b rdata=%h required 0 beef", if_rvalid_o, if_rdata_o); end
    endtask

    task automatic test_store_load();
        drive_edge();
        ram_lat = 1;
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 16'h0100; mem_wdata_i = 16'h1234;
        sample();
        checks++; if (mem_gnt_o !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b required 1", mem_gnt_o); end
        drive_edge();
        mem_req_i = 0; mem_we_i = 0;
        sample();
        checks++; if (ram_we_o !== 1'b1 || ram_wdata_o !== 16'h1234 || ram_addr_o !== 16'h0100) begin errors++; $display("FAIL store_ram: we=%b wdata=%h addr=%h required 1 1234 0100", ram_we_o, ram_wdata_o, ram_addr_o); end
        drive_edge();
        sample();
        checks++; if (mem_rvalid_o !== 1'b1 || mem_rdata_o !== 16'h0) begin errors++; $display("FAIL store_resp: rvalid=%b rdata=%h required 1 0000", mem_rvalid_o, mem_rdata_o); end
        drive_edge();
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 16'h0100;
        sample();
        checks++; if (mem_gnt_o !== 1'b1) begin errors++; $display("FAIL load_gnt: got %b required 1", mem_gnt_o); end
        drive_edge();
        mem_req_i = 0;
        sample();
        checks++; if (ram_we_o !== 1'b0 || ram_req_o !== 1'b1) begin errors++; $display("FAIL load_ram: we=%b req=%b required 0 1", ram_we_o, ram_req_o); end
        drive_edge();
        sample();
        checks++; if (mem_rvalid_o !== 1'b1 || mem_rdata_o !== 16'h1234) begin errors++; $display("FAIL load_resp: rvalid=%b rdata=%h required 1 1234", mem_rvalid_o, mem_rdata_o); end
    endtask

    task automatic test_contention();
        int n;
        int cyc;
        logic exp_if;
        drive_edge();
        ram_lat = 2;
        if_req_i = 1; if_addr_i = 16'h0050;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 16'h0060;
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            sample();
            checks++; if (if_gnt_o && mem_gnt_o) begin errors++; $display("FAIL contention_double_gnt: if_gnt=%b mem_gnt=%b required at most one", if_gnt_o, mem_gnt_o); end
            if (if_gnt_o || mem_gnt_o) begin
                exp_if = (n % 5 == 4);
                checks++; if (if_gnt_o !== exp_if) begin errors++; $display("FAIL contention_order[%0d]: if_gnt=%b required %b", n, if_gnt_o, exp_if); end
                n++;
            end
            cyc++;
            if (n < 10) drive_edge();
        end
        checks++; if (n != 10) begin errors++; $display("FAIL contention_timeout: grants=%0d required 10", n); end
        drive_edge();
        if_req_i = 0; mem_req_i = 0;
        sample();
        wait_idle("contention");
    endtask

    task automatic test_flush();
        int acks_before;
        drive_edge();
        ram_lat = 3;
        if_req_i = 1; if_addr_i = 16'h0020;
        sample();
        checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL flush_gnt: got %b required 1", if_gnt_o); end
        acks_before = ack_count;
        drive_edge();
        if_req_i = 0; if_flush_i = 1;
        sample();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b required 1", busy_o); end
        drive_edge();
        if_flush_i = 0;
        for (int k = 0; k < 5; k++) begin
            sample();
            checks++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== 16'hA050) begin errors++; $display("FAIL flush_suppress[%0d]: rvalid=%b rdata=%h required 0 a050", k, if_rvalid_o, if_rdata_o); end
            drive_edge();
        end
        sample();
        checks++; if (busy_o !== 1'b0 || ram_req_o !== 1'b0 || ack_count != acks_before + 1) begin errors++; $display("FAIL flush_completes: busy=%b req=%b acks=%0d required 0 0 %0d", busy_o, ram_req_o, ack_count - acks_before, 1); end
        drive_edge();
        ram_lat = 1;
        if_req_i = 1; if_addr_i = 16'h0030;
        sample();
        checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL flush_next_gnt: got %b required 1", if_gnt_o); end
        drive_edge();
        if_req_i = 0;
        sample();
        drive_edge();
        sample();
        checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 16'hA030) begin errors++; $display("FAIL flush_next_resp: rvalid=%b rdata=%h required 1 a030", if_rvalid_o, if_rdata_o); end
    endtask

    task automatic test_reset_mid();
        drive_edge();
        ram_lat = 10;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 16'h0040;
        sample();
        checks++; if (mem_gnt_o !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b required 1", mem_gnt_o); end
        drive_edge();
        mem_req_i = 0;
        sample();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b required 1", busy_o); end
        drive_edge();
        rst_i = 1;
        sample();
        drive_edge();
        rst_i = 0;
        sample();
        checks++; if (ram_req_o !== 1'b0 || busy_o !== 1'b0 || mem_rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid_after: req=%b busy=%b rvalid=%b required 0 0 0", ram_req_o, busy_o, mem_rvalid_o); end
        for (int k = 0; k < 3; k++) begin
            drive_edge();
            sample();
            checks++; if (mem_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d]: rvalid=%b busy=%b required 0 0", k, mem_rvalid_o, busy_o); end
        end
        drive_edge();
        man_ack = 1;
        sample();
        drive_edge();
        man_ack = 0;
        sample();
        checks++; if (mem_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_stray_ack: mem_rv=%b if_rv=%b busy=%b required 0 0 0", mem_rvalid_o, if_rvalid_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        drive_edge();
        ram_lat = 1;
        man_ack = 1;
        sample();
        checks++; if (mem_gnt_o !== 1'b0 || if_gnt_o !== 1'b0) begin errors++; $display("FAIL b2b_no_gnt: if=%b mem=%b required 0 0", if_gnt_o, mem_gnt_o); end
        drive_edge();
        man_ack = 0;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 16'h0100;
        sample();
        checks++; if (mem_rvalid_o !== 1'b0 || mem_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_first: rvalid=%b gnt=%b required 0 1", mem_rvalid_o, mem_gnt_o); end
        drive_edge();
        sample();
        checks++; if (mem_gnt_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy: gnt=%b busy=%b required 0 1", mem_gnt_o, busy_o); end
        drive_edge();
        sample();
        checks++; if (mem_rvalid_o !== 1'b1 || mem_rdata_o !== 16'h1234 || mem_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_turnaround: rvalid=%b rdata=%h gnt=%b required 1 1234 1", mem_rvalid_o, mem_rdata_o, mem_gnt_o); end
        drive_edge();
        mem_req_i = 0;
        sample();
        wait_idle("b2b");
    endtask

    // Transaction-level reference: owner of the RAM, tie-break streak, flush flag and expected responses.
    task automatic test_random();
        int          owner;
        int          streak;
        bit          flushed;
        bit          pend_we;
        logic [15:0] pend_addr;
        logic [15:0] pend_wdata;
        logic [15:0] pend_data;
        bit          exp_if_rv;
        bit          exp_mem_rv;
        logic [15:0] exp_if_rd;
        logic [15:0] exp_mem_rd;
        bit          e_ig;
        bit          e_mg;
        bit          last_ig;
        bit          last_mg;
        drive_edge();
        rst_i = 1;
        if_req_i = 0; mem_req_i = 0; if_flush_i = 0; man_ack = 0;
        ram_lat = 0;
        drive_edge();
        rst_i = 0;
        sample();
        for (int i = 0; i < 1024; i++) ref_mem[i] = ram_mem[i];
        owner = 0; streak = 0; flushed = 0; pend_we = 0;
        pend_addr = 0; pend_wdata = 0; pend_data = 0;
        exp_if_rv = 0; exp_mem_rv = 0; exp_if_rd = 0; exp_mem_rd = 0;
        last_ig = 0; last_mg = 0;
        for (int c = 0; c < 800; c++) begin
            drive_edge();
            if (!if_req_i || last_ig) begin
                if_req_i = ($urandom_range(0, 3) != 0);
                if_addr_i = 16'($urandom_range(0, 63));
            end
            if (!mem_req_i || last_mg) begin
                mem_req_i = ($urandom_range(0, 2) != 0);
                mem_we_i = $urandom_range(0, 1) == 1;
                mem_addr_i = 16'($urandom_range(0, 63));
                mem_wdata_i = 16'($urandom);
            end
            if_flush_i = ($urandom_range(0, 7) == 0);
            sample();
            e_ig = (owner == 0) && if_req_i && (!mem_req_i || streak == 4);
            e_mg = (owner == 0) && mem_req_i && !e_ig;
            checks++; if (if_gnt_o !== e_ig || mem_gnt_o !== e_mg) begin errors++; $display("FAIL rand_gnt@%0d: if=%b mem=%b required %b %b", c, if_gnt_o, mem_gnt_o, e_ig, e_mg); end
            checks++; if (if_rvalid_o !== exp_if_rv || if_rdata_o !== exp_if_rd) begin errors++; $display("FAIL rand_if_resp@%0d: rv=%b rd=%h required %b %h", c, if_rvalid_o, if_rdata_o, exp_if_rv, exp_if_rd); end
            checks++; if (mem_rvalid_o !== exp_mem_rv || mem_rdata_o !== exp_mem_rd) begin errors++; $display("FAIL rand_mem_resp@%0d: rv=%b rd=%h required %b %h", c, mem_rvalid_o, mem_rdata_o, exp_mem_rv, exp_mem_rd); end
            checks++; if (busy_o !== (owner != 0) || ram_req_o !== (owner != 0)) begin errors++; $display("FAIL rand_busy@%0d: busy=%b req=%b required %b", c, busy_o, ram_req_o, owner != 0); end
            if (owner != 0) begin
                checks++; if (ram_addr_o !== pend_addr || ram_we_o !== pend_we || (pend_we && ram_wdata_o !== pend_wdata) || (owner == 1 && ram_wdata_o !== 16'h0)) begin errors++; $display("FAIL rand_payload@%0d: addr=%h we=%b wdata=%h required %h %b %h", c, ram_addr_o, ram_we_o, ram_wdata_o, pend_addr, pend_we, pend_wdata); end
            end
            exp_if_rv = 0;
            exp_mem_rv = 0;
            if (owner == 1 && if_flush_i) flushed = 1;
            if (owner != 0 && ram_ack_i) begin
                if (owner == 1) begin
                    if (!flushed) begin
                        exp_if_rv = 1;
                        exp_if_rd = pend_data;
                    end
                end else begin
                    exp_mem_rv = 1;
                    exp_mem_rd = pend_we ? 16'h0 : pend_data;
                end
                flushed = 0;
                owner = 0;
            end
            if (e_ig) begin
                owner = 1;
                pend_we = 0; pend_addr = if_addr_i; pend_wdata = 16'h0;
                pend_data = ref_mem[if_addr_i[9:0]];
                if (if_flush_i) flushed = 1;
            end else if (e_mg) begin
                owner = 2;
                pend_we = mem_we_i; pend_addr = mem_addr_i; pend_wdata = mem_wdata_i;
                pend_data = ref_mem[mem_addr_i[9:0]];
                if (mem_we_i) ref_mem[mem_addr_i[9:0]] = mem_wdata_i;
            end
            if (e_ig || !if_req_i) streak = 0;
            else if (e_mg && streak < 4) streak++;
            last_ig = e_ig;
            last_mg = e_mg;
        end
        drive_edge();
        if_req_i = 0; mem_req_i = 0; if_flush_i = 0;
        sample();
        wait_idle("random");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_if_only();
        test_store_load();
        test_contention();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
